uart_tx_fifo: RTL and testbench
===============================

// Module: uart_tx_fifo
// PURPOSE
//  Buffered UART transmitter: accepts bytes over a valid/ready handshake into a
//  small FIFO and serializes them onto tx_o as 8-bit frames, LSB first, with an
//  optional parity bit. Sits between the core's MMIO/debug writer and the pad.
//  It is the transmit-side counterpart to the uart receive path.
// PARAMETERS
//  CLK_FREQ    100_000_000  system clock frequency, Hz
//  BAUD_RATE   115_200      line rate; DIV = CLK_FREQ/BAUD_RATE (integer div, >=2)
//  FIFO_DEPTH  16           entries; power of two, >=2
//  PARITY      0            0 none, 1 odd, 2 even
// PORTS
//  clk          in   1                  system clock, rising edge
//  rst_n        in   1                  async active-low reset
//  tx_data_i    in   8                  byte to send
//  tx_valid_i   in   1                  tx_data_i valid
//  tx_ready_o   out  1                  FIFO can accept (= !full)
//  tx_o         out  1                  serial line, idle high, registered
//  tx_busy_o    out  1                  FIFO non-empty or frame in flight
//  fifo_count_o out  $clog2(DEPTH)+1    entries currently held
// BEHAVIOUR
//  Reset (async, any time): tx_o=1, tx_ready_o=1, tx_busy_o=0, fifo_count_o=0;
//   FIFO pointers cleared, FSM->IDLE, bit/baud counters 0. Mid-frame: frame
//   aborted, line high at once, buffered bytes discarded.
//  Push: tx_valid_i && tx_ready_o at a rising edge writes tx_data_i; valid while
//   full is ignored (byte not stored; sender must hold it). Ready is comb !full.
//  Pop: done only by FSM in IDLE when count!=0. Push+pop same edge: count same.
//  Full + pop same edge: no push that edge (ready was low); ready rises next.
//  Pointers wrap modulo FIFO_DEPTH; count range 0..FIFO_DEPTH.
//  FSM states: IDLE, START, DATA, PARITY, STOP. Baud counter counts 0..DIV-1
//   per bit; each bit held on tx_o for exactly DIV clocks.
//   IDLE:   tx_o=1. If count!=0: pop head into shift reg, compute parity,
//           -> START (tx_o=0 from that edge).
//   START:  tx_o=0 for DIV clk -> DATA, bit idx 0.
//   DATA:   tx_o=shift[0], shift right each bit; after bit 7 -> PARITY if
//           PARITY!=0 else STOP.
//   PARITY: tx_o = even ? ^data : ~^data, DIV clk -> STOP.
//   STOP:   tx_o=1 for DIV clk -> IDLE.
//  Latency: byte pushed into empty FIFO at edge E0 with FSM idle -> popped at
//   E1, tx_o falls at E1. Frame = (10 or 11)*DIV clocks.
//  Back-to-back: STOP->IDLE costs exactly one extra high clock before the next
//   start bit (inter-frame line-high = DIV+1 clocks).
//  tx_busy_o = (state!=IDLE) || (count!=0); registered view of same edge.
//  Pushes during a frame never disturb the frame in flight.
// TESTING  (CLK_FREQ=100e6, BAUD_RATE=10e6 -> DIV=10, DEPTH=16)
//  1 Reset asserted, idle inputs -> tx_o=1, ready=1, busy=0, count=0.
//  2 PARITY=0, push 0xA5 once -> tx_o low 10 clk from next edge, then
//    1,0,1,0,0,1,0,1 at 10 clk each, high 10 clk; busy low after stop ends.
//  3 PARITY=2 push 0x07 -> parity bit 1; PARITY=1 push 0x07 -> parity bit 0;
//    frame 110 clocks.
//  4 Hold valid, push 0x00..0x10 (17 bytes) -> ready drops when count=16, all
//    17 bytes on line in order, each stop->start gap exactly 11 high clocks.
//  5 Push on same edge as IDLE pop (count=3) -> count stays 3; no byte lost.
//  6 Assert rst_n low during DATA bit 3 with 5 queued -> tx_o=1 immediately,
//    count=0; after release no frame is sent.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
//   Buffered UART transmitter. Bytes arrive over a valid/ready handshake into a
//   small FIFO and are sent on tx_o as 8N1 frames (or 8E1/8O1 with parity),
//   LSB first. Sits between the core's MMIO/debug writer and the pad.
//
//   state  | meaning
//   -------+--------------------------------------------------------------
//   IDLE   | line high; pops the FIFO head as soon as one is available
//   START  | start bit (low) for DIV clocks
//   DATA   | eight data bits, LSB first, DIV clocks each
//   PARITY | parity bit for DIV clocks (only when PARITY != 0)
//   STOP   | stop bit (high) for DIV clocks, then back to IDLE
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   tx_data_i    byte to send
//   tx_valid_i   tx_data_i valid
//   tx_ready_o   FIFO can accept a byte (combinational !full)
//   tx_o         serial line, idle high, registered
//   tx_busy_o    FIFO non-empty or frame in flight
//   fifo_count_o number of bytes currently buffered (0..FIFO_DEPTH)

module uart_tx_fifo #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD_RATE  = 115_200,
    parameter int FIFO_DEPTH = 16,
    parameter int PARITY     = 0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [7:0]                    tx_data_i,
    input  logic                          tx_valid_i,
    output logic                          tx_ready_o,
    output logic                          tx_o,
    output logic                          tx_busy_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o
);

    localparam int DIV = CLK_FREQ / BAUD_RATE;
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int BW  = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [BW-1:0] BAUD_LAST  = BW'(DIV - 1);
    localparam logic [AW:0]   FULL_COUNT = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;

    state_t        state_q;
    state_t        state_d;
    logic [BW-1:0] baud_q;
    logic [2:0]    bit_q;
    logic [7:0]    shift_q;
    logic          par_q;
    logic          tx_q;
    logic          tx_d;

    logic          full;
    logic          push;
    logic          pop;
    logic          baud_end;
    logic [7:0]    head;

    assign full     = (count_q == FULL_COUNT);
    assign push     = tx_valid_i && !full;
    assign pop      = (state_q == S_IDLE) && (count_q != '0);
    assign baud_end = (baud_q == BAUD_LAST);
    assign head     = mem[rd_ptr_q];

    assign tx_ready_o   = !full;
    assign tx_o         = tx_q;
    assign tx_busy_o    = (state_q != S_IDLE) || (count_q != '0);
    assign fifo_count_o = count_q;

    // FIFO storage needs no reset: pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= tx_data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + (AW + 1)'(1);
                2'b01:   count_q <= count_q - (AW + 1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Next state and next line level. tx_d is the level the line takes in the
    // next state, so tx_o comes straight from a flop and changes on the same
    // edge as the state.
    always_comb begin
        state_d = state_q;
        tx_d    = tx_q;
        case (state_q)
            S_IDLE: begin
                tx_d = 1'b1;
                if (pop) begin
                    state_d = S_START;
                    tx_d    = 1'b0;
                end
            end
            S_START: begin
                if (baud_end) begin
                    state_d = S_DATA;
                    tx_d    = shift_q[0];
                end
            end
            S_DATA: begin
                if (baud_end) begin
                    if (bit_q == 3'd7) begin
                        if (PARITY != 0) begin
                            state_d = S_PARITY;
                            tx_d    = par_q;
                        end else begin
                            state_d = S_STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        // shift_q moves right on this edge, so bit 1 is next
                        tx_d = shift_q[1];
                    end
                end
            end
            S_PARITY: begin
                if (baud_end) begin
                    state_d = S_STOP;
                    tx_d    = 1'b1;
                end
            end
            S_STOP: begin
                if (baud_end) begin
                    state_d = S_IDLE;
                    tx_d    = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            tx_q    <= tx_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
        end else begin
            if (state_q == S_IDLE || baud_end) begin
                baud_q <= '0;
            end else begin
                baud_q <= baud_q + BW'(1);
            end

            if (state_q == S_START && baud_end) begin
                bit_q <= 3'd0;
            end else if (state_q == S_DATA && baud_end) begin
                bit_q <= bit_q + 3'd1;
            end

            if (pop) begin
                shift_q <= head;
                par_q   <= (PARITY == 2) ? ^head : ~^head;
            end else if (state_q == S_DATA && baud_end) begin
                shift_q <= {1'b0, shift_q[7:1]};
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Testbench for uart_tx_fifo: three instances (no parity, odd, even) with
// DIV = 10, FIFO_DEPTH = 16. Single frames come from a table of hand-coded
// line patterns; fill, same-edge push/pop and mid-frame reset are sequences.

module tb_uart_tx_fifo;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] d0, d1, d2;
    logic       v0, v1, v2;
    logic       rdy0, rdy1, rdy2;
    logic       tx0, tx1, tx2;
    logic       busy0, busy1, busy2;
    logic [4:0] cnt0, cnt1, cnt2;

    uart_tx_fifo #(.CLK_FREQ(100_000_000), .BAUD_RATE(10_000_000),
                   .FIFO_DEPTH(16), .PARITY(0)) dut_none (
        .clk(clk), .rst_n(rst_n), .tx_data_i(d0), .tx_valid_i(v0),
        .tx_ready_o(rdy0), .tx_o(tx0), .tx_busy_o(busy0), .fifo_count_o(cnt0));

    uart_tx_fifo #(.CLK_FREQ(100_000_000), .BAUD_RATE(10_000_000),
                   .FIFO_DEPTH(16), .PARITY(1)) dut_odd (
        .clk(clk), .rst_n(rst_n), .tx_data_i(d1), .tx_valid_i(v1),
        .tx_ready_o(rdy1), .tx_o(tx1), .tx_busy_o(busy1), .fifo_count_o(cnt1));

    uart_tx_fifo #(.CLK_FREQ(100_000_000), .BAUD_RATE(10_000_000),
                   .FIFO_DEPTH(16), .PARITY(2)) dut_even (
        .clk(clk), .rst_n(rst_n), .tx_data_i(d2), .tx_valid_i(v2),
        .tx_ready_o(rdy2), .tx_o(tx2), .tx_busy_o(busy2), .fifo_count_o(cnt2));

    // bits[i] is the line level during bit period i (0 = start bit).
    typedef struct {
        int         sel;
        logic [7:0] data;
        logic [10:0] bits;
        int         nbits;
    } frame_vec_t;

    frame_vec_t vecs [7];
    logic [7:0] exp_q [$];

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic get_tx(input int sel);
        case (sel)
            0:       return tx0;
            1:       return tx1;
            default: return tx2;
        endcase
    endfunction

    function automatic logic get_busy(input int sel);
        case (sel)
            0:       return busy0;
            1:       return busy1;
            default: return busy2;
        endcase
    endfunction

    function automatic logic [4:0] get_cnt(input int sel);
        case (sel)
            0:       return cnt0;
            1:       return cnt1;
            default: return cnt2;
        endcase
    endfunction

    task automatic drive(input int sel, input logic v, input logic [7:0] d);
        case (sel)
            0:       begin v0 = v; d0 = d; end
            1:       begin v1 = v; d1 = d; end
            default: begin v2 = v; d2 = d; end
        endcase
    endtask

    task automatic push_byte(input int sel, input logic [7:0] d);
        drive(sel, 1'b1, d);
        @(posedge clk);
        #1;
        drive(sel, 1'b0, 8'h00);
    endtask

    task automatic check_frame(input int idx, input frame_vec_t fv);
        logic [10:0] bits;
        bits = fv.bits;
        push_byte(fv.sel, fv.data);
        @(negedge clk);
        chk($sformatf("v%0d_pre_start_tx", idx), get_tx(fv.sel), 1);
        chk($sformatf("v%0d_queued_busy", idx), get_busy(fv.sel), 1);
        chk($sformatf("v%0d_queued_count", idx), get_cnt(fv.sel), 1);
        for (int i = 0; i < fv.nbits * 10; i++) begin
            @(negedge clk);
            chk($sformatf("v%0d_bit%0d_clk%0d", idx, i / 10, i % 10), get_tx(fv.sel), bits[i / 10]);
        end
        @(negedge clk);
        chk($sformatf("v%0d_end_busy", idx), get_busy(fv.sel), 0);
        chk($sformatf("v%0d_end_tx", idx), get_tx(fv.sel), 1);
    endtask

    // Back-to-back frames on the no-parity instance: each frame slot is
    // 100 clocks of frame plus one idle-high clock.
    task automatic check_stream(input string tag);
        int n;
        int f;
        int r;
        logic [7:0] b;
        logic e;
        n = exp_q.size();
        @(posedge clk);
        @(negedge clk);
        chk({tag, "_pre_start_tx"}, tx0, 1);
        for (int i = 0; i < n * 101; i++) begin
            @(negedge clk);
            f = i / 101;
            r = i % 101;
            b = exp_q[f];
            if (r < 10)      e = 1'b0;
            else if (r < 90) e = b[(r - 10) / 10];
            else             e = 1'b1;
            chk($sformatf("%s_f%0d_r%0d", tag, f, r), tx0, e);
        end
        chk({tag, "_end_busy"}, busy0, 0);
        chk({tag, "_end_count"}, cnt0, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no completion, want finish within 2 ms");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{sel: 0, data: 8'hA5, bits: 11'b0_1_10100101_0, nbits: 10};
        vecs[1] = '{sel: 2, data: 8'h07, bits: 11'b1_1_00000111_0, nbits: 11};
        vecs[2] = '{sel: 1, data: 8'h07, bits: 11'b1_0_00000111_0, nbits: 11};
        vecs[3] = '{sel: 0, data: 8'h3C, bits: 11'b0_1_00111100_0, nbits: 10};
        vecs[4] = '{sel: 2, data: 8'hFF, bits: 11'b1_0_11111111_0, nbits: 11};
        vecs[5] = '{sel: 1, data: 8'h80, bits: 11'b1_0_10000000_0, nbits: 11};
        vecs[6] = '{sel: 1, data: 8'h00, bits: 11'b1_1_00000000_0, nbits: 11};

        v0 = 1'b0; v1 = 1'b0; v2 = 1'b0;
        d0 = 8'h00; d1 = 8'h00; d2 = 8'h00;

        // reset state
        repeat (3) @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            chk($sformatf("rst_tx_%0d", s), get_tx(s), 1);
            chk($sformatf("rst_busy_%0d", s), get_busy(s), 0);
            chk($sformatf("rst_count_%0d", s), get_cnt(s), 0);
        end
        chk("rst_ready_0", rdy0, 1);
        chk("rst_ready_1", rdy1, 1);
        chk("rst_ready_2", rdy2, 1);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_tx_0", tx0, 1);

        // single frames
        for (int k = 0; k < 7; k++) begin
            check_frame(k, vecs[k]);
        end

        // fill: 17 bytes with valid held, ready drops at count 16
        exp_q.delete();
        for (int b = 0; b < 17; b++) exp_q.push_back(8'(b));
        fork
            begin
                for (int b = 0; b < 17; b++) begin
                    v0 = 1'b1;
                    d0 = 8'(b);
                    chk($sformatf("fill_ready_b%0d", b), rdy0, 1);
                    @(posedge clk);
                    #1;
                end
                v0 = 1'b0;
                chk("fill_full_count", cnt0, 16);
                chk("fill_full_ready", rdy0, 0);
                repeat (85) @(posedge clk);
                #1;
                chk("fill_still_full", cnt0, 16);
                @(posedge clk);
                #1;
                chk("fill_after_pop_count", cnt0, 15);
                chk("fill_after_pop_ready", rdy0, 1);
            end
            check_stream("fill");
        join

        // push on the same edge as the IDLE pop with three queued
        exp_q.delete();
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h22);
        exp_q.push_back(8'h33);
        exp_q.push_back(8'h44);
        exp_q.push_back(8'h55);
        fork
            begin
                v0 = 1'b1; d0 = 8'h11;
                @(posedge clk); #1;
                v0 = 1'b0;
                @(posedge clk); #1;
                v0 = 1'b1; d0 = 8'h22;
                @(posedge clk); #1;
                d0 = 8'h33;
                @(posedge clk); #1;
                d0 = 8'h44;
                @(posedge clk); #1;
                v0 = 1'b0;
                chk("pp_queued_count", cnt0, 3);
                repeat (97) @(posedge clk);
                #1;
                chk("pp_idle_count", cnt0, 3);
                chk("pp_idle_tx", tx0, 1);
                chk("pp_idle_busy", busy0, 1);
                v0 = 1'b1; d0 = 8'h55;
                chk("pp_ready", rdy0, 1);
                @(posedge clk); #1;
                v0 = 1'b0;
                chk("pp_same_edge_count", cnt0, 3);
                chk("pp_start_tx", tx0, 0);
            end
            check_stream("pushpop");
        join

        // reset during DATA bit 3 with five bytes queued
        push_byte(0, 8'hA5);
        v0 = 1'b1; d0 = 8'h60;
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk); #1;
            d0 = 8'(8'h60 + k);
        end
        v0 = 1'b0;
        chk("mr_queued_count", cnt0, 5);
        repeat (41) @(posedge clk);
        #3;
        chk("mr_bit3_tx", tx0, 0);
        rst_n = 1'b0;
        #1;
        chk("mr_rst_tx", tx0, 1);
        chk("mr_rst_count", cnt0, 0);
        chk("mr_rst_busy", busy0, 0);
        chk("mr_rst_ready", rdy0, 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 250; i++) begin
            @(negedge clk);
            chk($sformatf("mr_quiet_tx_%0d", i), tx0, 1);
        end
        chk("mr_quiet_busy", busy0, 0);
        chk("mr_quiet_count", cnt0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
